// File: rtl/color_pkg.sv
// Shared colour types and per-channel arithmetic for the RGB display path.
`timescale 1ns/1ps
package color_pkg;

  localparam int unsigned CHAN_W = 8;

  typedef struct packed {
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } rgb_t;

  // Floor-divide each channel by 2^shift independently; no carry between channels.
  function automatic rgb_t rgb_shr(rgb_t c, logic [2:0] shift);
    rgb_t res;
    res.r = c.r >> shift;
    res.g = c.g >> shift;
    res.b = c.b >> shift;
    return res;
  endfunction

endpackage

// File: rtl/color_fade_in.sv
// Latches a target colour, starts it dimmed by 2^START_SHIFT and doubles brightness
// every STEP_CYCLES clocks until full colour is reached.
`timescale 1ns/1ps
module color_fade_in
  import color_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 1000,
  parameter int unsigned START_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] color_in,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CntW    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STEP_CYCLES - 1);
  localparam logic [2:0]  StartSh = 3'(START_SHIFT);

  typedef enum logic [0:0] {StIdle, StRamp} state_e;

  state_e          state_q;
  rgb_t            color_q;
  logic [2:0]      shift_q;
  logic [CntW-1:0] step_cnt;
  rgb_t            start_rgb;
  rgb_t            step_rgb;

  assign start_rgb = rgb_shr(rgb_t'(color_in), StartSh);
  assign step_rgb  = rgb_shr(color_q, shift_q - 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      color_q  <= '0;
      shift_q  <= '0;
      step_cnt <= '0;
      r_out    <= '0;
      g_out    <= '0;
      b_out    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      // A start wins over a step boundary landing on the same edge.
      if (start) begin
        color_q  <= rgb_t'(color_in);
        shift_q  <= StartSh;
        step_cnt <= '0;
        r_out    <= start_rgb.r;
        g_out    <= start_rgb.g;
        b_out    <= start_rgb.b;
        if (StartSh == 3'd0) begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b1;
        end else begin
          state_q <= StRamp;
          busy    <= 1'b1;
        end
      end else if (state_q == StRamp) begin
        if (step_cnt == CntLast) begin
          step_cnt <= '0;
          shift_q  <= shift_q - 3'd1;
          r_out    <= step_rgb.r;
          g_out    <= step_rgb.g;
          b_out    <= step_rgb.b;
          if (shift_q == 3'd1) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_color_fade_in.sv
// Randomised and directed bench for color_fade_in against a timeline-based model.
`timescale 1ns/1ps
module tb_color_fade_in;

  localparam int Step = 4;
  localparam int Shift = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [23:0] color_in = '0;
  logic [7:0]  r_a, g_a, b_a, r_z, g_z, b_z;
  logic        busy_a, done_a, busy_z, done_z;

  int vectors = 0;
  int miscompares = 0;

  // Model state: when the current fade began and which colour it targets.
  int          cyc = 0;
  bit          m_valid = 1'b0;
  int          m_t0 = 0;
  logic [23:0] m_col = '0;

  color_fade_in #(.STEP_CYCLES(Step), .START_SHIFT(Shift)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .color_in(color_in),
    .r_out(r_a), .g_out(g_a), .b_out(b_a), .busy(busy_a), .done(done_a)
  );

  color_fade_in #(.STEP_CYCLES(Step), .START_SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .color_in(color_in),
    .r_out(r_z), .g_out(g_z), .b_out(b_z), .busy(busy_z), .done(done_z)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (rst_n && start) begin
      m_valid = 1'b1;
      m_t0    = cyc;
      m_col   = color_in;
    end
  end

  always @(negedge rst_n) m_valid = 1'b0;

  // {r, g, b, busy, done} expected after (elapsed) edges since the start edge.
  function automatic logic [25:0] model_out(int shift, int elapsed, bit valid,
                                            logic [23:0] col);
    int lv;
    int s;
    if (!valid) return '0;
    lv = elapsed / Step;
    if (lv >= shift) return {col, 1'b0, (elapsed == shift * Step) ? 1'b1 : 1'b0};
    s = shift - lv;
    return {col[23:16] >> s, col[15:8] >> s, col[7:0] >> s, 1'b1, 1'b0};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    check("model_shift2", {6'd0, r_a, g_a, b_a, busy_a, done_a},
          {6'd0, model_out(Shift, cyc - m_t0, m_valid, m_col)});
    check("model_shift0", {6'd0, r_z, g_z, b_z, busy_z, done_z},
          {6'd0, model_out(0, cyc - m_t0, m_valid, m_col)});
  end

  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(logic [23:0] c);
    @(negedge clk);
    #1;
    start    = 1'b1;
    color_in = c;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("reset_out", {6'd0, r_a, g_a, b_a, busy_a, done_a}, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    edges(20);
    check("reset_hold", {6'd0, r_a, g_a, b_a, busy_a, done_a}, 32'h0);

    // Basic fade of white.
    do_start(24'hFFFFFF);
    check("basic_e0", {7'd0, r_a, g_a, b_a, busy_a}, {7'd0, 24'h3F3F3F, 1'b1});
    check("shift0_e0", {6'd0, r_z, g_z, b_z, busy_z, done_z}, {6'd0, 24'hFFFFFF, 2'b01});
    edges(4);
    check("basic_e4", {6'd0, r_a, g_a, b_a, busy_a, done_a}, {6'd0, 24'h7F7F7F, 2'b10});
    edges(4);
    check("basic_e8", {6'd0, r_a, g_a, b_a, busy_a, done_a}, {6'd0, 24'hFFFFFF, 2'b01});
    edges(1);
    check("basic_e9", {6'd0, r_a, g_a, b_a, busy_a, done_a}, {6'd0, 24'hFFFFFF, 2'b00});
    edges(5);

    // Channels shift independently.
    do_start(24'h007F7F);
    check("chan_e0", {8'd0, r_a, g_a, b_a}, {8'd0, 24'h001F1F});
    edges(4);
    check("chan_e4", {8'd0, r_a, g_a, b_a}, {8'd0, 24'h003F3F});
    edges(4);
    check("chan_e8", {8'd0, r_a, g_a, b_a}, {8'd0, 24'h007F7F});
    edges(3);

    // Restart mid-fade at E5.
    do_start(24'hFFFFFF);
    edges(4);
    do_start(24'h00FF00);
    check("restart_e5", {6'd0, r_a, g_a, b_a, busy_a, done_a}, {6'd0, 24'h003F00, 2'b10});
    edges(4);
    check("restart_e9", {6'd0, r_a, g_a, b_a, busy_a, done_a}, {6'd0, 24'h007F00, 2'b10});
    edges(4);
    check("restart_e13", {6'd0, r_a, g_a, b_a, busy_a, done_a}, {6'd0, 24'h00FF00, 2'b01});
    edges(2);

    // Zero start shift passes colour straight through.
    do_start(24'h123456);
    check("shift0_123456", {6'd0, r_z, g_z, b_z, busy_z, done_z}, {6'd0, 24'h123456, 2'b01});
    edges(3);

    // Asynchronous reset mid-fade.
    do_start(24'hA0B0C0);
    edges(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {6'd0, r_a, g_a, b_a, busy_a, done_a}, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    edges(10);
    check("after_rst", {6'd0, r_a, g_a, b_a, busy_a, done_a}, 32'h0);

    // Random starts and colours, with occasional reset pulses.
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      #1;
      start    = ($urandom_range(0, 13) == 0);
      color_in = 24'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    #1 start = 1'b0;
    edges(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/color_fade_in.md
# color_fade_in

Timed brightness restorer for the RGB display path. It latches a 24-bit target colour and starts output at that colour divided by 2^START_SHIFT, the same floor-division dimming the display path already applies per channel. It then doubles brightness once every STEP_CYCLES clocks until the full colour is reached. It sits between the colour source and the LED/pixel output stage, so dimmed elements can fade back in over time instead of jumping to full brightness.

## Interface
- STEP_CYCLES, 1000: clock cycles spent at each brightness level; legal range ≥1.
- START_SHIFT, 2: initial right-shift per channel (2 = quarter brightness); legal range 0..7.
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; samples color_in.
- color_in  in  24  target colour {r[23:16], g[15:8], b[7:0]}.
- r_out  out  8  registered red output.
- g_out  out  8  registered green output.
- b_out  out  8  registered blue output.
- busy  out  1  high while ramping.
- done  out  1  one-cycle pulse when full colour is first driven.

## Operation
- States: IDLE and RAMP.
- Registers:
  - color_q: 24-bit latched colour.
  - shift_q: 3-bit current shift.
  - step_cnt: counts 0..STEP_CYCLES-1; width is clog2(STEP_CYCLES), minimum 1.
- Reset values: state=IDLE, color_q=0, shift_q=0, step_cnt=0, r/g/b_out=0, busy=0, done=0.
- IDLE:
  - Outputs hold their last value.
  - start=1 → latch color_in, shift_q=START_SHIFT, step_cnt=0, drive each channel = color_in channel >> START_SHIFT.
  - If START_SHIFT=0: stay in IDLE and pulse done in that same update; busy stays 0.
  - Otherwise: go to RAMP with busy=1.
- RAMP:
  - step_cnt increments each cycle.
  - When step_cnt = STEP_CYCLES-1: step_cnt←0, shift_q←shift_q-1, outputs ← color_q channels >> (shift_q-1).
  - If the new shift is 0: go to IDLE, busy←0, done←1 for exactly one cycle.
- start during RAMP restarts the fade: re-latch color_in, reload shift and counter, no done pulse. start has priority over a simultaneous step boundary.
- Arithmetic: per-channel logical right shift of an 8-bit value (floor), no rounding and no cross-channel carry; 0xFF>>2=0x3F, 0xFF>>1=0x7F.
- color_in is ignored except on start cycles.
- rst_n asserted mid-ramp forces reset values immediately (asynchronously); no done pulse.

## Timing
- Edge numbering: start sampled on edge E0; the initial dimmed outputs and busy=1 are visible after E0.
- Each shift level lasts exactly STEP_CYCLES cycles.
- Full colour and done=1 appear after edge E0 + START_SHIFT·STEP_CYCLES. busy falls on that same edge.
- done is a registered pulse, high for one cycle, coincident with the first full-colour cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- A restart at edge Ek restarts the timeline with Ek as the new E0.

## Structure
- Shared package color_pkg holds:
  - the rgb_t packed struct {r,g,b} of 8 bits each;
  - the constant CHAN_W=8;
  - a function rgb_shr(rgb_t, shift) returning the per-channel floor shift.
- The display-path scaler can later adopt color_pkg.
- No sub-module: the FSM, counter and three shifters form one module.

## Test plan
- Reset: rst_n=0 → all outputs 0, busy=0, done=0; release and hold 20 cycles → unchanged.
- Basic fade, STEP_CYCLES=4, START_SHIFT=2, start with color_in=FFFFFF:
  - after E0: 3F3F3F, busy=1;
  - after E4: 7F7F7F;
  - after E8: FFFFFF, done=1 for one cycle, busy=0;
  - outputs stay FFFFFF afterwards.
- Per-channel independence: color_in=007F7F → 001F1F, then 003F3F, then 007F7F; red stays 00 throughout.
- Restart: start with FFFFFF, then start with 00FF00 at E5 → after E5: 003F00; after E9: 007F00; after E13: 00FF00 with a single done pulse.
- Edge cases:
  - START_SHIFT=0, color_in=123456 → 123456 after E0, done=1, busy never rises.
  - rst_n pulsed low at E3 of a fade → immediate zeros, no done.
